// File: rtl/demux_sched_pkg.sv
// Shared types and constants for the 1:8 demux burst scheduler.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package demux_sched_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PICK = 2'd1,
        XFER = 2'd2
    } state_t;

    // Channel that follows ch in circular order; wraps 7 -> 0 through the 3-bit width.
    function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] ch);
        return ch + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Circular priority encoder: first set bit of i_mask at or after i_start, wrapping 7 -> 0.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_mask  - candidate channels
//        i_start - channel searched first
//        o_idx   - chosen channel (0 when nothing found)
//        o_found - at least one mask bit set
module rr_pick8
    import demux_sched_pkg::*;
(
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [SEL_W-1:0]  i_start,
    output logic [SEL_W-1:0]  o_idx,
    output logic              o_found
);

    logic [SEL_W-1:0] w_idx;
    logic             w_found;
    logic [SEL_W-1:0] w_cand;

    always_comb begin
        w_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            // 3-bit addition wraps naturally, giving the circular order
            w_cand = i_start + SEL_W'(k);
            if (!w_found && i_mask[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    assign o_idx   = w_idx;
    assign o_found = w_found;

endmodule

// File: rtl/demux_burst_sched.sv
// Round-robin burst scheduler driving the 1:8 demux select, BURST_LEN beats per channel.
// Latency: first beat accepted 2 cycles after en & |mask is sampled; one PICK cycle per burst.
// Backpressure: in_ready follows out_ready[sel] & ch_mask[sel]; beat count holds while stalled.
// Ports: i_clk/i_rst (sync, active-high), i_en, i_ch_mask[7:0],
//        i_in_valid/i_in_data/o_in_ready (source side),
//        o_sel, o_out_valid[7:0] (one-hot), o_out_data, i_out_ready[7:0] (destination side),
//        o_busy (not IDLE), o_burst_done (registered 1-cycle pulse after last beat).
module demux_burst_sched
    import demux_sched_pkg::*;
#(
    parameter int DATA_W    = 1,
    parameter int BURST_LEN = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [NUM_CH-1:0] i_ch_mask,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_in_ready,
    output logic [SEL_W-1:0]  o_sel,
    output logic [NUM_CH-1:0] o_out_valid,
    output logic [DATA_W-1:0] o_out_data,
    input  logic [NUM_CH-1:0] i_out_ready,
    output logic              o_busy,
    output logic              o_burst_done
);

    localparam int               CNT_W     = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN);

    state_t           r_state;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_last_ch;
    logic [CNT_W-1:0] r_beat_cnt;
    logic             r_burst_done;

    logic [SEL_W-1:0]  w_start;
    logic [SEL_W-1:0]  w_pick_idx;
    logic              w_pick_found;
    logic              w_xfer;
    logic              w_ch_en;
    logic              w_in_ready;
    logic              w_beat;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [NUM_CH-1:0] w_out_valid;

    // Search begins one past the last served channel so every enabled channel gets a turn.
    assign w_start = next_ch(r_last_ch);

    rr_pick8 u_pick (
        .i_mask  (i_ch_mask),
        .i_start (w_start),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    assign w_xfer     = (r_state == XFER);
    assign w_ch_en    = i_ch_mask[r_sel];
    assign w_in_ready = w_xfer & i_out_ready[r_sel] & w_ch_en;
    assign w_beat     = w_in_ready & i_in_valid;
    assign w_cnt_inc  = r_beat_cnt + 1'b1;

    always_comb begin
        w_out_valid = '0;
        if (w_xfer) begin
            w_out_valid[r_sel] = i_in_valid & w_ch_en;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_sel        <= '0;
            r_last_ch    <= SEL_W'(NUM_CH - 1);
            r_beat_cnt   <= '0;
            r_burst_done <= 1'b0;
        end else begin
            r_burst_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_en && (|i_ch_mask)) begin
                        r_state <= PICK;
                    end
                end
                PICK: begin
                    // Mask may have been cleared since IDLE was left; fall back if so.
                    if (w_pick_found) begin
                        r_sel      <= w_pick_idx;
                        r_last_ch  <= w_pick_idx;
                        r_beat_cnt <= '0;
                        r_state    <= XFER;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                XFER: begin
                    if (!w_ch_en) begin
                        // Channel disabled under us: drop the burst without a done pulse.
                        r_state <= i_en ? PICK : IDLE;
                    end else if (w_beat) begin
                        r_beat_cnt <= w_cnt_inc;
                        if (w_cnt_inc == LAST_BEAT) begin
                            r_burst_done <= 1'b1;
                            r_state      <= i_en ? PICK : IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_in_ready   = w_in_ready;
    assign o_sel        = r_sel;
    assign o_out_valid  = w_out_valid;
    assign o_out_data   = i_in_data;
    assign o_busy       = (r_state != IDLE);
    assign o_burst_done = r_burst_done;

endmodule

// File: tb/tb_demux_burst_sched.sv
// Testbench for demux_burst_sched: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level model of the scheduler.
module tb_demux_burst_sched;

    localparam int BL = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [7:0]    mask;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [7:0]    out_ready;

    logic          o_in_ready;
    logic [2:0]    o_sel;
    logic [7:0]    o_out_valid;
    logic [DW-1:0] o_out_data;
    logic          o_busy;
    logic          o_burst_done;

    always #5 clk = ~clk;

    demux_burst_sched #(.DATA_W(DW), .BURST_LEN(BL)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_ch_mask    (mask),
        .i_in_valid   (in_valid),
        .i_in_data    (in_data),
        .o_in_ready   (o_in_ready),
        .o_sel        (o_sel),
        .o_out_valid  (o_out_valid),
        .o_out_data   (o_out_data),
        .i_out_ready  (out_ready),
        .o_busy       (o_busy),
        .o_burst_done (o_burst_done)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: is a burst open, on which channel, how many beats so far,
    // is a channel selection owed next cycle, and the registered done pulse.
    bit m_open     = 0;
    bit m_pick_due = 0;
    bit m_done     = 0;
    int m_ch       = 0;
    int m_last     = 7;
    int m_got      = 0;

    // Observation logs taken from the DUT's outputs
    int cyc = 0;
    int log_ch[$];
    int log_cyc[$];
    int beats_on[8];
    int masked_viol = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_cycle();
        logic [7:0] e_ov;
        logic       e_rdy;
        bit         found;
        int         c;
        cyc++;
        e_rdy = m_open && out_ready[m_ch] && mask[m_ch];
        e_ov  = '0;
        if (m_open && in_valid && mask[m_ch]) e_ov[m_ch] = 1'b1;

        chk("busy",       o_busy,       m_open || m_pick_due);
        chk("sel",        o_sel,        m_ch);
        chk("in_ready",   o_in_ready,   e_rdy);
        chk("out_valid",  o_out_valid,  e_ov);
        chk("burst_done", o_burst_done, m_done);
        chk("out_data",   o_out_data,   in_data);

        if (o_burst_done) begin
            log_ch.push_back(int'(o_sel));
            log_cyc.push_back(cyc);
        end
        if (o_in_ready && in_valid && !rst) beats_on[o_sel]++;
        if ((o_out_valid & ~mask) != 8'h00) masked_viol++;

        if (rst) begin
            m_open = 0; m_pick_due = 0; m_done = 0;
            m_ch = 0; m_last = 7; m_got = 0;
        end else begin
            m_done = 0;
            if (m_open) begin
                if (!mask[m_ch]) begin
                    m_open     = 0;
                    m_pick_due = en;
                end else if (e_rdy && in_valid) begin
                    m_got++;
                    if (m_got == BL) begin
                        m_done     = 1;
                        m_open     = 0;
                        m_pick_due = en;
                    end
                end
            end else if (m_pick_due) begin
                m_pick_due = 0;
                found      = 0;
                for (int k = 1; k <= 8; k++) begin
                    c = (m_last + k) % 8;
                    if (!found && mask[c]) begin
                        found  = 1;
                        m_ch   = c;
                        m_last = c;
                        m_got  = 0;
                        m_open = 1;
                    end
                end
            end else if (en && mask != 8'h00) begin
                m_pick_due = 1;
            end
        end
    endtask

    // Each step runs the model/compare at the falling edge, then returns just after the rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            model_cycle();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        int s;
        int b0, b1, b3, b4, b5;

        rst = 1'b1; en = 1'b1; mask = 8'hFF; in_valid = 1'b1;
        in_data = 8'h5A; out_ready = 8'hFF;
        step(2);
        // Reset state with every input asking for traffic
        chk("rst_sel",      o_sel,        0);
        chk("rst_busy",     o_busy,       0);
        chk("rst_in_ready", o_in_ready,   0);
        chk("rst_out_vld",  o_out_valid,  0);
        chk("rst_done",     o_burst_done, 0);

        // Test 1: full mask, no stalls; IDLE -> PICK -> XFER latency
        rst = 1'b0;
        s   = log_ch.size();
        b0  = beats_on[0];
        b1  = beats_on[1];
        step(1);
        chk("t1_pick_busy",  o_busy,     1);
        chk("t1_pick_rdy",   o_in_ready, 0);
        step(1);
        chk("t1_first_rdy",  o_in_ready, 1);
        chk("t1_first_sel",  o_sel,      0);
        for (int i = 0; i < 300 && log_ch.size() < s + 9; i++) step(1);
        chk("t1_nbursts", log_ch.size() >= s + 9, 1);
        for (int k = 0; k < 9; k++) chk("t1_seq", log_ch[s+k], k % 8);
        for (int k = 0; k < 8; k++) chk("t1_gap", log_cyc[s+k+1] - log_cyc[s+k], BL + 1);
        chk("t1_beats_ch0", beats_on[0] - b0, 2 * BL);
        chk("t1_beats_ch1", beats_on[1] - b1, BL);
        en = 1'b0;
        for (int i = 0; i < 50 && o_busy; i++) step(1);
        chk("t1_drain", o_busy, 0);

        // Test 2: sparse mask 2,5,7
        en = 1'b1; mask = 8'b1010_0100;
        do_reset();
        s = log_ch.size();
        for (int i = 0; i < 200 && log_ch.size() < s + 4; i++) step(1);
        chk("t2_seq0", log_ch[s],   2);
        chk("t2_seq1", log_ch[s+1], 5);
        chk("t2_seq2", log_ch[s+2], 7);
        chk("t2_seq3", log_ch[s+3], 2);
        chk("t2_masked", masked_viol, 0);

        // Test 3: stall channel 3 for 3 cycles after beat 2
        mask = 8'h08;
        do_reset();
        b3 = beats_on[3];
        for (int i = 0; i < 50 && beats_on[3] - b3 < 2; i++) step(1);
        chk("t3_two_beats", beats_on[3] - b3, 2);
        out_ready = 8'hF7;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_stall_rdy", o_in_ready, 0);
            step(1);
        end
        chk("t3_held", beats_on[3] - b3, 2);
        out_ready = 8'hFF;
        s = log_ch.size();
        for (int i = 0; i < 50 && log_ch.size() <= s; i++) step(1);
        chk("t3_done_ch", log_ch[s], 3);
        chk("t3_beats",   beats_on[3] - b3, BL);

        // Test 4: clear channel 1 mid-burst
        mask = 8'h12;
        do_reset();
        b1 = beats_on[1];
        b4 = beats_on[4];
        for (int i = 0; i < 50 && beats_on[1] - b1 < 2; i++) step(1);
        chk("t4_two_beats", beats_on[1] - b1, 2);
        mask = 8'h10;
        s = log_ch.size();
        for (int i = 0; i < 50 && log_ch.size() <= s; i++) step(1);
        chk("t4_next_ch",  log_ch[s], 4);
        chk("t4_ch1_beats", beats_on[1] - b1, 2);
        chk("t4_ch4_beats", beats_on[4] - b4, BL);

        // Test 5: empty mask keeps the block idle; en drop lets the burst finish
        mask = 8'h00;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("t5_idle_busy", o_busy,     0);
            chk("t5_idle_rdy",  o_in_ready, 0);
        end
        mask = 8'hFF;
        b0 = beats_on[0];
        b1 = beats_on[1];
        for (int i = 0; i < 20 && beats_on[0] - b0 < 1; i++) step(1);
        en = 1'b0;
        for (int i = 0; i < 20 && o_busy; i++) step(1);
        chk("t5_stop_busy", o_busy, 0);
        chk("t5_ch0_beats", beats_on[0] - b0, BL);
        step(5);
        chk("t5_still_idle", o_busy, 0);
        chk("t5_no_ch1",     beats_on[1] - b1, 0);

        // Test 6: reset in the middle of a channel-5 burst
        en = 1'b1; mask = 8'hFF;
        do_reset();
        b5 = beats_on[5];
        for (int i = 0; i < 100 && beats_on[5] - b5 < 2; i++) step(1);
        chk("t6_ch5_two", beats_on[5] - b5, 2);
        rst = 1'b1;
        step(1);
        chk("t6_sel",     o_sel,        0);
        chk("t6_busy",    o_busy,       0);
        chk("t6_rdy",     o_in_ready,   0);
        chk("t6_out_vld", o_out_valid,  0);
        chk("t6_done",    o_burst_done, 0);
        rst = 1'b0;
        s = log_ch.size();
        for (int i = 0; i < 50 && log_ch.size() <= s; i++) step(1);
        chk("t6_next_ch",   log_ch[s], 0);
        chk("t6_ch5_total", beats_on[5] - b5, 2);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = DW'($urandom);
            out_ready = 8'($urandom);
            if ($urandom_range(0, 19) == 0) mask = 8'($urandom) & 8'($urandom | 32'h1);
            if ($urandom_range(0, 49) == 0) en = ~en;
            if ($urandom_range(0, 99) == 0) en = 1'b1;
            rst = ($urandom_range(0, 299) == 0);
            step(1);
        end
        rst = 1'b0;
        chk("rand_masked", masked_viol, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
